// File: rtl/ncl_pkg.sv
// Shared NCL types: FSM states, dual-rail pair encoding.
// Used by ncl_word_tx and ncl_sync based receivers.
package ncl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    NULL = 2'd2
  } ncl_tx_state_t;

  typedef struct packed {
    logic t;
    logic f;
  } ncl_dr_t;

  localparam ncl_dr_t NCL_NULL = 2'b00;
  localparam ncl_dr_t NCL_D1   = 2'b10;
  localparam ncl_dr_t NCL_D0   = 2'b01;

  function automatic ncl_dr_t ncl_enc(input logic b);
    return b ? NCL_D1 : NCL_D0;
  endfunction

endpackage

// File: rtl/ncl_sync.sv
// STAGES-deep flop synchronizer, async active-low reset.
// Ports: clk, rst_n, d_i (async in), q_o (synchronized out).
module ncl_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ncl_word_tx.sv
// Sync-to-NCL transmitter: valid/ready words -> dual-rail DATA/NULL.
// Ports: clk, rst_n, in_valid/in_ready/in_data, tx_t/tx_f, ko, busy, err.
// Optional watchdog on DATA/NULL waits: define NCL_TX_WATCHDOG_EN.
module ncl_word_tx
  import ncl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] tx_t,
  output logic [WIDTH-1:0] tx_f,
  input  logic             ko,
  output logic             busy,
  output logic             err
);

  ncl_tx_state_t state_q, state_d;
  ncl_dr_t [WIDTH-1:0] rail_q, rail_d;
  logic ko_s;

  ncl_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ko),
    .q_o   (ko_s)
  );

  assign in_ready = (state_q == IDLE) & ko_s;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    rail_d  = rail_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && ko_s) begin
          state_d = DATA;
          for (int i = 0; i < WIDTH; i++)
            rail_d[i] = ncl_enc(in_data[i]);
        end
      end
      DATA: begin
        if (!ko_s) begin
          state_d = NULL;
          for (int i = 0; i < WIDTH; i++)
            rail_d[i] = NCL_NULL;
        end
      end
      NULL: begin
        if (ko_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        for (int i = 0; i < WIDTH; i++)
          rail_d[i] = NCL_NULL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rail_q  <= '0;
    end else begin
      state_q <= state_d;
      rail_q  <= rail_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_rail
    assign tx_t[g] = rail_q[g].t;
    assign tx_f[g] = rail_q[g].f;
  end

`ifdef NCL_TX_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;

  // Count wait cycles in DATA/NULL; restart on every state change.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = '0;
    else if (busy && cnt_q != TMAX) cnt_d = cnt_q + 1'b1;
    err_d = err_q | (busy && cnt_d == TMAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ncl_word_tx.sv
// Directed bench for ncl_word_tx (WIDTH=8, SYNC_STAGES=2).
// Watchdog steps only in builds with NCL_TX_WATCHDOG_EN.
module tb_ncl_word_tx;

  logic       clk = 0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] tx_t, tx_f;
  logic       ko;
  logic       busy, err;

  logic ko_man  = 1'b1;
  logic ko_auto = 1'b1;
  logic auto    = 1'b0;
  logic cap     = 1'b0;
  logic prev_null = 1'b1;
  logic [7:0] seen[$];

  int checks   = 0;
  int failures = 0;

  assign ko = auto ? ko_auto : ko_man;

  ncl_word_tx #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .tx_t     (tx_t),
    .tx_f     (tx_f),
    .ko       (ko),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 60) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 60), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 60), 1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #3;
    @(negedge clk);
    rst_n = 1;
  endtask

  // Receiver model: ask for NULL while DATA is seen, DATA otherwise.
  always @(posedge clk) ko_auto <= !(|(tx_t | tx_f));

  always @(negedge clk) begin
    chk("no_1_1", 32'(tx_t & tx_f), 0);
    if (|(tx_t | tx_f)) begin
      chk("full_wave", 32'(tx_t | tx_f), 32'hFF);
      if (cap && prev_null) seen.push_back(tx_t);
    end
    prev_null = !(|(tx_t | tx_f));
  end

  initial begin
    rst_n = 0; in_valid = 0; in_data = 0; ko_man = 1;
    #12;
    chk("rst_t", 32'(tx_t), 0);
    chk("rst_f", 32'(tx_f), 0);
    chk("rst_rdy", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1;
    in_valid = 1; in_data = 8'hA5;

    tick();
    chk("rdy_c1", 32'(in_ready), 0);
    tick();
    chk("rdy_c2", 32'(in_ready), 1);
    tick();
    chk("a5_t", 32'(tx_t), 32'hA5);
    chk("a5_f", 32'(tx_f), 32'h5A);
    chk("a5_busy", 32'(busy), 1);
    chk("a5_rdy", 32'(in_ready), 0);
    in_valid = 0; in_data = 8'h00;

    ko_man = 0;
    tick(2);
    chk("null_e2", 32'(tx_t), 32'hA5);
    tick();
    chk("null_e3_t", 32'(tx_t), 0);
    chk("null_e3_f", 32'(tx_f), 0);
    chk("null_busy", 32'(busy), 1);
    ko_man = 1;
    tick(2);
    chk("rdy_back_e2", 32'(in_ready), 0);
    tick();
    chk("rdy_back_e3", 32'(in_ready), 1);
    chk("idle_busy", 32'(busy), 0);

    auto = 1; cap = 1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: in_data = 8'h00;
        1: in_data = 8'hFF;
        default: in_data = 8'h3C;
      endcase
      in_valid = 1;
      wait_ready("b2b_rdy");
      tick();
      in_valid = 0;
      in_data = 8'h99;
    end
    wait_idle("b2b_idle");
    tick(4);
    cap = 0; auto = 0;
    chk("b2b_cnt", 32'(seen.size()), 3);
    if (seen.size() == 3) begin
      chk("b2b_w0", 32'(seen[0]), 32'h00);
      chk("b2b_w1", 32'(seen[1]), 32'hFF);
      chk("b2b_w2", 32'(seen[2]), 32'h3C);
    end

    ko_man = 0; in_valid = 1; in_data = 8'h55;
    do_reset();
    for (int k = 0; k < 10; k++) tick();
    chk("ko0_rdy", 32'(in_ready), 0);
    chk("ko0_t", 32'(tx_t), 0);
    chk("ko0_f", 32'(tx_f), 0);
    chk("ko0_busy", 32'(busy), 0);
    in_valid = 0;

    ko_man = 1;
    do_reset();
    in_valid = 1; in_data = 8'hC3;
    wait_ready("c3_rdy");
    tick();
    in_valid = 0;
    chk("c3_t", 32'(tx_t), 32'hC3);
    chk("c3_f", 32'(tx_f), 32'h3C);
    #2;
    rst_n = 0;
    #1;
    chk("arst_t", 32'(tx_t), 0);
    chk("arst_f", 32'(tx_f), 0);
    chk("arst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1;
    tick(6);
    chk("noresend_t", 32'(tx_t), 0);
    chk("noresend_busy", 32'(busy), 0);
    chk("noresend_rdy", 32'(in_ready), 1);

    in_valid = 1; in_data = 8'h0F;
    tick();
    in_valid = 0;
    chk("wd_data", 32'(tx_t), 32'h0F);
    tick(15);
`ifdef NCL_TX_WATCHDOG_EN
    chk("wd_15", 32'(err), 0);
    tick();
    chk("wd_16", 32'(err), 1);
    ko_man = 0;
    tick(5);
    ko_man = 1;
    tick(5);
    chk("wd_sticky", 32'(err), 1);
    chk("wd_idle", 32'(busy), 0);
    do_reset();
    #1;
    chk("wd_clr", 32'(err), 0);
`else
    tick(5);
    chk("no_wd_err", 32'(err), 0);
    chk("no_wd_busy", 32'(busy), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ncl_word_tx.md
# ncl_word_tx

Synchronous-to-NCL boundary transmitter. Accepts single-rail words from the clocked side over a valid/ready handshake and drives them into the asynchronous NCL datapath as dual-rail DATA/NULL wavefronts. It feeds the NCL instruction decode/control logic, for example the instruction bits I7..I4. It sequences the four-phase return-to-NULL protocol from the receiver's completion acknowledge (`ko`), which it synchronizes into the clock domain.

## Interface
- `WIDTH`, 8: data word width (number of dual-rail pairs)
- `SYNC_STAGES`, 2: flip-flop stages on the `ko` synchronizer (min 2)
- `TIMEOUT`, 255: wait-cycle limit for the watchdog (only with `NCL_TX_WATCHDOG_EN`)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  word on `in_data` is valid
- `in_ready`  out  1  transmitter can accept a word this cycle
- `in_data`  in  WIDTH  single-rail word
- `tx_t`  out  WIDTH  true rails, registered
- `tx_f`  out  WIDTH  false rails, registered
- `ko`  in  1  async completion ack from the receiver: 1 = request-for-data, 0 = request-for-null
- `busy`  out  1  a wavefront is in flight (state is not IDLE)
- `err`  out  1  sticky watchdog timeout flag

## Operation
- Rail encoding per bit: NULL = (t,f) = (0,0); DATA 1 = (1,0); DATA 0 = (0,1). (1,1) is illegal and must never be driven.
- `ko` passes through an SYNC_STAGES-deep synchronizer to produce `ko_s`. Logic uses only `ko_s`.
- State machine:
  - IDLE: rails NULL. `in_ready = ko_s`. On `in_valid & in_ready`, register `in_data` and go to DATA.
  - DATA: `tx_t = word`, `tx_f = ~word`. `in_ready = 0`. When `ko_s == 0`, go to NULL.
  - NULL: rails NULL. `in_ready = 0`. When `ko_s == 1`, go to IDLE.
- All rails change in the same clock edge from registers, with no partial wavefronts. DATA↔NULL transitions are monotonic per rail.
- `in_data` is sampled only at acceptance. Changes to it during DATA or NULL have no effect.
- `busy = (state != IDLE)`.

## Timing
- Reset values: `tx_t = 0`, `tx_f = 0`, `in_ready = 0`, `busy = 0`, `err = 0`, state IDLE, synchronizer flops 0.
- After reset, `in_ready` rises SYNC_STAGES cycles after `ko` is seen high.
- Accept at edge N. DATA appears on the rails after edge N, which is 1-cycle latency.
- `ko` falls. The rails go NULL SYNC_STAGES+1 edges later. `ko` rises. `in_ready` is high SYNC_STAGES+1 edges later.
- Minimum cycle per word: 2·(SYNC_STAGES+1) clocks plus the receiver delays.
- If `ko` is high and steady, nothing is ever dropped. `in_valid` held without `in_ready` simply waits.
- Reset mid-wavefront: the rails go NULL asynchronously and the word is discarded. After reset the block waits for `ko_s == 1` before accepting.
- A `ko` glitch shorter than the synchronizer resolution is a receiver protocol violation, and behaviour is undefined beyond "no illegal (1,1) rail".

## Configuration
- `NCL_TX_WATCHDOG_EN` defined:
  - A counter runs in DATA and NULL and clears on each state change.
  - If it reaches TIMEOUT, `err` is set and stays set until reset.
  - The FSM keeps waiting and does not abort the wavefront.
- Not defined: there is no counter, and `err` is tied to 0.

## Structure
- Package `ncl_pkg` holds:
  - The state enum `ncl_tx_state_t` {IDLE, DATA, NULL}.
  - The dual-rail pair typedef `ncl_dr_t` {t, f}.
  - Constants `NCL_NULL` = 2'b00, `NCL_D1` = 2'b10, `NCL_D0` = 2'b01.
- Sub-module `ncl_sync`: a parameterised SYNC_STAGES-deep synchronizer with async active-low reset. It is reused by future NCL-to-sync receivers.

## Test plan
- Reset, hold `ko = 1`, drive `in_data = 8'hA5` valid:
  - `in_ready` is high at cycle 2, accept happens, next cycle `tx_t = 8'hA5`, `tx_f = 8'h5A`.
- After DATA, drop `ko`:
  - Rails go 0/0 exactly SYNC_STAGES+1 clocks later.
  - Raising `ko` then brings `in_ready` back high SYNC_STAGES+1 clocks later.
- Send back-to-back words 8'h00, 8'hFF, 8'h3C with an automated `ko` responder:
  - All three appear in order.
  - No cycle has any bit with `tx_t & tx_f`.
  - A NULL appears between each word.
- Hold `ko = 0` from reset with `in_valid = 1`:
  - `in_ready` stays 0, rails stay NULL, and no word is accepted.
- Assert `rst_n = 0` while in the DATA state with word 8'hC3:
  - Rails go 0/0 immediately without waiting for a clock edge.
  - `busy = 0`, and the word is never re-sent.
- With `NCL_TX_WATCHDOG_EN` and `TIMEOUT = 16`, hold `ko = 1` after the DATA launch:
  - `err` rises after 16 wait cycles and stays high after `ko` toggles.
  - It clears only on reset.
